// File: rtl/peg_scorer.sv
// Sequential Mastermind scorer: exact matches over four positions, then color-only
// matches from per-color histograms; results drive four 2-bit peg digits plus win/game-over.
module peg_scorer #(
    parameter int NUM_COLORS = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       last_turn,
    input  logic [2:0] code0,
    input  logic [2:0] code1,
    input  logic [2:0] code2,
    input  logic [2:0] code3,
    input  logic [2:0] guess0,
    input  logic [2:0] guess1,
    input  logic [2:0] guess2,
    input  logic [2:0] guess3,
    output logic       busy,
    output logic       done,
    output logic [2:0] exact,
    output logic [2:0] partial,
    output logic [1:0] peg0,
    output logic [1:0] peg1,
    output logic [1:0] peg2,
    output logic [1:0] peg3,
    output logic       win,
    output logic       game_over
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXACT,
        S_PARTIAL,
        S_DONE
    } state_t;

    state_t     r_state;
    logic [2:0] r_idx;
    logic [2:0] r_code  [4];
    logic [2:0] r_guess [4];
    logic       r_last_turn;
    logic [2:0] r_exact_acc;
    logic [2:0] r_partial_acc;
    logic [2:0] r_hc [NUM_COLORS];
    logic [2:0] r_hg [NUM_COLORS];

    logic [2:0] w_code_idx;
    logic [2:0] w_guess_idx;
    logic [2:0] w_min;
    logic [2:0] w_partial_next;
    logic [2:0] w_total;
    logic       w_win;
    logic [1:0] w_peg [4];

    // The final PARTIAL step folds its own min() in before the outputs are loaded.
    always_comb begin
        w_code_idx     = r_code[r_idx[1:0]];
        w_guess_idx    = r_guess[r_idx[1:0]];
        w_min          = (r_hc[r_idx] < r_hg[r_idx]) ? r_hc[r_idx] : r_hg[r_idx];
        w_partial_next = r_partial_acc + w_min;
        w_total        = r_exact_acc + w_partial_next;
        w_win          = (r_exact_acc == 3'd4);
        for (int p = 0; p < 4; p++) begin
            if (3'(p) < r_exact_acc)
                w_peg[p] = 2'd2;
            else if (3'(p) < w_total)
                w_peg[p] = 2'd1;
            else
                w_peg[p] = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_last_turn   <= 1'b0;
            r_exact_acc   <= '0;
            r_partial_acc <= '0;
            for (int i = 0; i < 4; i++) begin
                r_code[i]  <= '0;
                r_guess[i] <= '0;
            end
            // NOTE: the histograms are small register arrays that must read as zero after reset, so they are reset explicitly.
            for (int i = 0; i < NUM_COLORS; i++) begin
                r_hc[i] <= '0;
                r_hg[i] <= '0;
            end
            busy      <= 1'b0;
            done      <= 1'b0;
            exact     <= '0;
            partial   <= '0;
            peg0      <= '0;
            peg1      <= '0;
            peg2      <= '0;
            peg3      <= '0;
            win       <= 1'b0;
            game_over <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_code[0]     <= code0;
                        r_code[1]     <= code1;
                        r_code[2]     <= code2;
                        r_code[3]     <= code3;
                        r_guess[0]    <= guess0;
                        r_guess[1]    <= guess1;
                        r_guess[2]    <= guess2;
                        r_guess[3]    <= guess3;
                        r_last_turn   <= last_turn;
                        r_exact_acc   <= '0;
                        r_partial_acc <= '0;
                        r_idx         <= '0;
                        for (int i = 0; i < NUM_COLORS; i++) begin
                            r_hc[i] <= '0;
                            r_hg[i] <= '0;
                        end
                        busy    <= 1'b1;
                        r_state <= S_EXACT;
                    end
                end
                S_EXACT: begin
                    if (w_code_idx == w_guess_idx) begin
                        r_exact_acc <= r_exact_acc + 3'd1;
                    end else begin
                        r_hc[w_code_idx]  <= r_hc[w_code_idx] + 3'd1;
                        r_hg[w_guess_idx] <= r_hg[w_guess_idx] + 3'd1;
                    end
                    if (r_idx == 3'd3) begin
                        r_idx   <= '0;
                        r_state <= S_PARTIAL;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                S_PARTIAL: begin
                    r_partial_acc <= w_partial_next;
                    if (r_idx == 3'(NUM_COLORS - 1)) begin
                        exact     <= r_exact_acc;
                        partial   <= w_partial_next;
                        win       <= w_win;
                        game_over <= game_over | w_win | r_last_turn;
                        peg0      <= w_peg[0];
                        peg1      <= w_peg[1];
                        peg2      <= w_peg[2];
                        peg3      <= w_peg[3];
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
